// File: rtl/signed_2s_comp_add.sv
// Registered signed two's-complement adder.
// The sum comes from a ripple chain of full adders. Overflow is detected from
// the carries into and out of the MSB. Outputs are registered with 1-cycle latency.
// Optional macro SIGNED_ADD_SAT_EN clamps the sum on signed overflow.

// Single-bit full adder, one per bit position of the chain.
module sa_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module signed_2s_comp_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  output logic [WIDTH-1:0] s_add,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sum_fin;

  logic             vld_q,  vld_d;
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cry_q,  cry_d;
  logic             ovf_q,  ovf_d;
  logic             neg_q,  neg_d;
  logic             zro_q,  zro_d;

  assign cy[0] = 1'b0;

  // The ripple chain has one full adder per bit, and carry-in is 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    sa_full_adder u_fa (
      .a_i (num1[i]),
      .b_i (num2[i]),
      .c_i (cy[i]),
      .s_o (sum_c[i]),
      .c_o (cy[i+1])
    );
  end

  assign carry_c = cy[WIDTH];
  // Signed overflow is set when the carry into the MSB differs from the carry out of it.
  assign ovf_c   = cy[WIDTH] ^ cy[MSB];

`ifdef SIGNED_ADD_SAT_EN
  // On overflow, clamp toward the sign of the operands (both operands share it when overflow occurs).
  always_comb begin
    sum_fin = sum_c;
    if (ovf_c) sum_fin = num1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_fin = sum_c;
`endif

  // Next state: load on valid. Otherwise hold the data and drop valid.
  always_comb begin
    vld_d = in_valid;
    sum_d = sum_q;
    cry_d = cry_q;
    ovf_d = ovf_q;
    neg_d = neg_q;
    zro_d = zro_q;
    if (in_valid) begin
      sum_d = sum_fin;
      cry_d = carry_c;
      ovf_d = ovf_c;
      neg_d = sum_fin[MSB];
      zro_d = (sum_fin == '0);
    end
  end

  // Output registers with async clear. Flags are registered so they read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sum_q <= '0;
      cry_q <= 1'b0;
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
      zro_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      sum_q <= sum_d;
      cry_q <= cry_d;
      ovf_q <= ovf_d;
      neg_q <= neg_d;
      zro_q <= zro_d;
    end
  end

  assign out_valid = vld_q;
  assign s_add     = sum_q;
  assign carry     = cry_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign zero      = zro_q;
endmodule

// File: tb/tb_signed_2s_comp_add.sv
// Self-checking bench for signed_2s_comp_add (WIDTH=32).
// It uses randomized and directed stimulus and compares results against a signed-integer reference model.
module tb_signed_2s_comp_add;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic         out_valid;
  logic [W-1:0] s_add;
  logic         carry, overflow, negative, zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         n;
    logic         z;
  } res_t;

  signed_2s_comp_add #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num1(num1), .num2(num2),
    .out_valid(out_valid), .s_add(s_add), .carry(carry), .overflow(overflow),
    .negative(negative), .zero(zero)
  );

  always #5 clk = ~clk;

  // The reference model uses exact signed arithmetic, then applies a range check.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint sa, sb, s, mx, mn, ua, ub, clamped;
    logic [W-1:0] wrapped;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = sa + sb;
    mx = (longint'(1) <<< (W-1)) - 1;
    mn = -(longint'(1) <<< (W-1));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r.c = ((ua + ub) >= (longint'(1) <<< W));
    r.o = (s > mx) || (s < mn);
    wrapped = s[W-1:0];
`ifdef SIGNED_ADD_SAT_EN
    clamped = (s > mx) ? mx : (s < mn) ? mn : s;
    r.s = clamped[W-1:0];
`else
    clamped = s;
    r.s = wrapped;
`endif
    r.n = r.s[W-1];
    r.z = (r.s == '0);
    return r;
  endfunction

  function automatic res_t observed();
    return '{s: s_add, c: carry, o: overflow, n: negative, z: zero};
  endfunction

  // Drives one valid pair before an edge and returns 1 time unit after that edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; num1 = a; num2 = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, s_add, carry, overflow, negative, zero} !== '0) begin
      fails++;
      $display("FAIL reset_async: got vld=%b s=%h c=%b o=%b n=%b z=%b, want all 0",
               out_valid, s_add, carry, overflow, negative, zero);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle_valid: got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] a [8];
    logic [W-1:0] b [8];
    logic [W-1:0] e [8];
    res_t exp_r;
    a[0] = 1010;      b[0] = 1000;       e[0] = 2010;
    a[1] = -1001253;  b[1] = -263784;    e[1] = -1265037;
    a[2] = 263;       b[2] = -27383;     e[2] = -27120;
    a[3] = -2526393;  b[3] = 5363;       e[3] = -2521030;
    a[4] = -263;      b[4] = 27383;      e[4] = 27120;
    a[5] = 2526393;   b[5] = -5363;      e[5] = 2521030;
    a[6] = -263233;   b[6] = 27383;      e[6] = -235850;
    a[7] = 25263;     b[7] = -536336;    e[7] = -511073;
    for (int i = 0; i < 8; i++) begin
      drive(a[i], b[i]);
      exp_r = model(a[i], b[i]);
      tests++;
      if (out_valid !== 1'b1 || s_add !== e[i] || overflow !== 1'b0 || negative !== e[i][W-1]) begin
        fails++;
        $display("FAIL directed_%0d: got vld=%b s=%0d o=%b n=%b, want vld=1 s=%0d o=0 n=%b",
                 i, out_valid, $signed(s_add), overflow, negative, $signed(e[i]), e[i][W-1]);
      end
      tests++;
      if (observed() !== exp_r) begin
        fails++;
        $display("FAIL directed_flags_%0d: got %h want %h", i, observed(), exp_r);
      end
    end
  endtask

  task automatic test_overflow();
    res_t exp_p, exp_n;
`ifdef SIGNED_ADD_SAT_EN
    exp_p = '{s: 32'h7FFF_FFFF, c: 1'b0, o: 1'b1, n: 1'b0, z: 1'b0};
    exp_n = '{s: 32'h8000_0000, c: 1'b1, o: 1'b1, n: 1'b1, z: 1'b0};
`else
    exp_p = '{s: 32'h8000_0000, c: 1'b0, o: 1'b1, n: 1'b1, z: 1'b0};
    exp_n = '{s: 32'h0000_0000, c: 1'b1, o: 1'b1, n: 1'b0, z: 1'b1};
`endif
    drive(32'h7FFF_FFFF, 32'h0000_0001);
    tests++;
    if (observed() !== exp_p || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pos_overflow: got vld=%b %h want vld=1 %h", out_valid, observed(), exp_p);
    end
    drive(32'h8000_0000, 32'h8000_0000);
    tests++;
    if (observed() !== exp_n || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL neg_overflow: got vld=%b %h want vld=1 %h", out_valid, observed(), exp_n);
    end
  endtask

  task automatic test_cancel_hold();
    drive(32'd12345, -32'sd12345);
    tests++;
    if (s_add !== '0 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0 || negative !== 1'b0) begin
      fails++;
      $display("FAIL cancel: got s=%h z=%b c=%b o=%b n=%b want s=0 z=1 c=1 o=0 n=0",
               s_add, zero, carry, overflow, negative);
    end
    @(negedge clk); in_valid = 1'b0; num1 = 'x; num2 = 'x;
    repeat (2) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || s_add !== '0 || zero !== 1'b1 || carry !== 1'b1) begin
        fails++;
        $display("FAIL hold: got vld=%b s=%h z=%b c=%b want vld=0 s=0 z=1 c=1",
                 out_valid, s_add, zero, carry);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    res_t exp_r;
    int bad = 0;
    for (int k = 0; k < 100; k++) begin
      a = $urandom;
      b = $urandom;
      // Bias some pairs toward the sign boundaries so overflow is exercised.
      if (k % 10 == 3) begin a[W-1:W-2] = 2'b01; b[W-1:W-2] = 2'b01; end
      if (k % 10 == 7) begin a[W-1:W-2] = 2'b10; b[W-1:W-2] = 2'b10; end
      drive(a, b);
      exp_r = model(a, b);
      tests++;
      if (out_valid !== 1'b1 || observed() !== exp_r) begin
        fails++; bad++;
        if (bad < 5)
          $display("FAIL b2b_%0d: a=%h b=%h got vld=%b %h want vld=1 %h",
                   k, a, b, out_valid, observed(), exp_r);
      end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); in_valid = 1'b1; num1 = 32'd5; num2 = 32'd6;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || s_add !== '0) begin
      fails++;
      $display("FAIL reset_mid: got vld=%b s=%h want vld=0 s=0", out_valid, s_add);
    end
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_idle: got vld=%b want 0", out_valid);
    end
    drive(32'd7, 32'd8);
    tests++;
    if (out_valid !== 1'b1 || s_add !== 32'd15) begin
      fails++;
      $display("FAIL reset_mid_resume: got vld=%b s=%0d want vld=1 s=15", out_valid, s_add);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_cancel_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/signed_2s_comp_add.md
Name: signed_2s_comp_add

Overview:
Registered signed two's-complement adder for the datapath: adds two WIDTH-bit signed operands and returns the WIDTH-bit sum plus status flags, one clock after the operands are accepted. The sum path is a structural ripple-carry chain of single-bit full adders, with overflow detection on the sign bits. Typical use is as the signed add stage feeding downstream arithmetic or compare logic.

Parameters:
WIDTH, 32, operand and sum width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  num1/num2 are valid this cycle
num1  input  WIDTH  signed operand A, two's complement
num2  input  WIDTH  signed operand B, two's complement
out_valid  output  1  s_add and flags are valid
s_add  output  WIDTH  signed sum A+B, low WIDTH bits (or saturated, see Optional Feature)
carry  output  1  unsigned carry out of the MSB
overflow  output  1  signed overflow occurred
negative  output  1  equals s_add[WIDTH-1]
zero  output  1  s_add is all zeros

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: rst_n low immediately clears out_valid, s_add, carry, overflow, negative and zero to 0, regardless of clk. Release is sampled on the next rising clk edge.
- Combinational core:
  - Ripple-carry chain of WIDTH full adders with carry-in 0.
  - sum_c = (num1 + num2) mod 2^WIDTH.
  - carry_c = carry out of bit WIDTH-1.
  - overflow_c = (num1[MSB] == num2[MSB]) && (sum_c[MSB] != num1[MSB]). This is equivalent to the carry into the MSB XOR carry_c.
- Latency: exactly 1 cycle.
  - On a rising clk edge with in_valid=1, all outputs load from the core and out_valid is set to 1.
  - On an edge with in_valid=0, out_valid goes to 0 and s_add and all flags hold their previous values.
- Throughput: one addition per cycle. Back-to-back valid inputs produce back-to-back results. There is no backpressure and no stall.
- Flags are computed from the final registered s_add value, which is the post-saturation value when the optional feature is enabled:
  - negative = s_add[MSB].
  - zero = (s_add == 0).
  - carry and overflow always reflect the raw wrapped addition.
- Boundary cases:
  - Mixed-sign operands never overflow.
  - Most-negative + most-negative (0x80000000 + 0x80000000 at WIDTH=32) gives sum 0, carry=1, overflow=1, zero=1 when not saturating.
  - A + (-A) gives 0, zero=1, overflow=0, carry=1 for nonzero A.
  - If reset is asserted mid-stream, any pending result is discarded and out_valid stays 0 until the first valid input after release.
- Inputs are sampled only at clock edges. X on num1/num2 while in_valid=0 must not affect outputs.

Optional Feature:
- Macro SIGNED_ADD_SAT_EN.
- When defined: on overflow, s_add is clamped.
  - Positive overflow (both operands non-negative) gives 2^(WIDTH-1)-1.
  - Negative overflow gives -2^(WIDTH-1).
  - overflow still reports 1, and negative/zero follow the clamped value.
- When undefined: s_add is the wrapped modulo-2^WIDTH sum and no clamp logic is synthesized.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; release, hold in_valid=0 -> out_valid stays 0.
- Directed sums at WIDTH=32 (one per cycle, in_valid=1), each result on the following edge with overflow=0:
  - 1010+1000 -> 2010
  - -1001253+(-263784) -> -1265037, negative=1
  - 263+(-27383) -> -27120
  - -2526393+5363 -> -2521030
  - -263+27383 -> 27120
  - 2526393+(-5363) -> 2521030
  - -263233+27383 -> -235850
  - 25263+(-536336) -> -511073
- Positive overflow: 0x7FFFFFFF+1 -> overflow=1, carry=0. s_add=0x80000000 without the macro; 0x7FFFFFFF with SIGNED_ADD_SAT_EN.
- Negative overflow: 0x80000000+0x80000000 -> overflow=1, carry=1. s_add=0 and zero=1 without the macro; 0x80000000, negative=1, zero=0 with the macro.
- Cancellation and hold: 12345+(-12345) -> s_add=0, zero=1, carry=1; then in_valid=0 for 2 cycles -> out_valid=0 with s_add held at 0.
- Throughput: 100 random back-to-back valid pairs -> every result matches a golden model of the modulo sum and signed-overflow flag, with 1-cycle latency and no gaps.
